// File: rtl/ps_result_reader.sv
// ps_result_reader: per accelerator run, start the PL core, wait for its done handshake, then drain
// NWORDS result words from BRAM into a ready/valid stream through a 2-entry FIFO.
// Optional watchdog on the START/ACK handshake when PS_RESULT_READER_TIMEOUT_EN is defined.
module ps_result_reader #(
   parameter int T              = 32,
   parameter int NWORDS         = 900,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   runs,
   output logic         busy,
   output logic         done,
   output logic [T-1:0] ps_control,
   input  logic [T-1:0] pl_status,
   output logic [T-1:0] n_val,
   output logic [T-1:0] bram_oc_addr,
   output logic         bram_oc_en,
   output logic [3:0]   bram_oc_we,
   input  logic [T-1:0] bram_oc_rddata,
   output logic [T-1:0] out_data,
   output logic         out_valid,
   output logic         out_last,
   input  logic         out_ready,
   output logic         error
);
   localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
   localparam logic [T-1:0] LAST_ADDR = T'(4 * (NWORDS - 1));
   typedef enum logic [2:0] {IDLE, START, ACK, DRAIN, FLUSH, NEXT} state_t;
   state_t        state;
   logic [7:0]    runs_q;
   logic [7:0]    run_cnt;
   logic [CW-1:0] out_cnt;
   logic          inflight;
   logic [1:0]    count;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [T-1:0]  mem [2];
   logic          pop;
   logic          unused_bits;
`ifdef PS_RESULT_READER_TIMEOUT_EN
   logic [31:0]   wd;
   logic          err_q;
   assign error = err_q;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign error = 1'b0;
`endif
   assign unused_bits = ^pl_status[T-1:1];
   assign pop         = out_valid && out_ready;
   assign out_valid   = count != 2'd0;
   assign out_data    = mem[rd_ptr];
   assign out_last    = out_valid && out_cnt == CW'(NWORDS - 1);
   assign busy        = state != IDLE;
   assign ps_control  = {{(T-1){1'b0}}, state == START};
   assign n_val       = T'(state == DRAIN || state == FLUSH);
   assign bram_oc_we  = 4'h0;
   // a read may issue only if the FIFO can still hold it after this cycle's pop
   assign bram_oc_en  = state == DRAIN && ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

   // two-entry result FIFO, written the cycle after each enabled read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight <= 1'b0;
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         mem[0]   <= '0;
         mem[1]   <= '0;
      end else begin
         inflight <= bram_oc_en;
         if (inflight) begin
            mem[wr_ptr] <= bram_oc_rddata;
            wr_ptr      <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         count <= count + {1'b0, inflight} - {1'b0, pop};
      end
   end

   // run sequencing: handshake with the accelerator, drain, repeat per run
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         done         <= 1'b0;
         runs_q       <= 8'd0;
         run_cnt      <= 8'd0;
         bram_oc_addr <= '0;
         out_cnt      <= '0;
`ifdef PS_RESULT_READER_TIMEOUT_EN
         wd           <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (pop) out_cnt <= out_last ? '0 : out_cnt + CW'(1);
         case (state)
            IDLE: if (start) begin
               state   <= START;
               runs_q  <= runs == 8'd0 ? 8'd1 : runs;
               run_cnt <= 8'd0;
`ifdef PS_RESULT_READER_TIMEOUT_EN
               err_q   <= 1'b0;
`endif
            end
            START: if (pl_status[0]) state <= ACK;
            ACK: if (!pl_status[0]) begin
               state        <= DRAIN;
               bram_oc_addr <= '0;
               out_cnt      <= '0;
            end
            DRAIN: if (bram_oc_en) begin
               if (bram_oc_addr == LAST_ADDR) state <= FLUSH;
               else bram_oc_addr <= bram_oc_addr + T'(4);
            end
            FLUSH: if (pop && out_last) state <= NEXT;
            NEXT: if ({1'b0, run_cnt} + 9'd1 < {1'b0, runs_q}) begin
               state   <= START;
               run_cnt <= run_cnt + 8'd1;
            end else begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
`ifdef PS_RESULT_READER_TIMEOUT_EN
         wd <= ((state == START && !pl_status[0]) || (state == ACK && pl_status[0])) ? wd + 32'd1 : '0;
         if ((state == START || state == ACK) && wd == 32'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            err_q <= 1'b1;
         end
`endif
      end
   end
endmodule

// File: tb/tb_ps_result_reader.sv
// tb_ps_result_reader: table-driven and randomized requests checked against a word-stream model
module tb_ps_result_reader;
   localparam int T  = 32;
   localparam int NW = 900;
   typedef struct {
      logic [7:0] runs;
      int         pct;
      int         dly;
      bit         force1;
      bit         mid;
      int         exp_words;
      int         exp_pc;
   } vec_t;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   runs = 8'd0;
   logic         busy, done, bram_oc_en, out_valid, out_last, error;
   logic [T-1:0] ps_control, n_val, bram_oc_addr, out_data, pl_status;
   logic [T-1:0] bram_oc_rddata = '0;
   logic [3:0]   bram_oc_we;
   logic         out_ready = 1'b0;
   int checks = 0, errors = 0;
   int pct = 100, acc_dly = 10;
   bit acc_force1 = 1'b0, acc_stuck0 = 1'b0;
   logic pl0 = 1'b0, pc_prev = 1'b0;
   int hi_c = 0, lo_c = 0, run_salt = 0;
   int cyc = 0, xfer = 0, issued = 0, max_out = 0, done_cnt = 0, pc_cyc = 0;
   int misc_err = 0, span_bad = 0, first_en = -1, first_val = -1, t0 = 0, salt_base = 0, idx;
   logic [31:0] exp_d;

   ps_result_reader #(.T(T), .NWORDS(NW), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .reset(rst_n), .start(start), .runs(runs), .busy(busy), .done(done),
      .ps_control(ps_control), .pl_status(pl_status), .n_val(n_val), .bram_oc_addr(bram_oc_addr),
      .bram_oc_en(bram_oc_en), .bram_oc_we(bram_oc_we), .bram_oc_rddata(bram_oc_rddata),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .error(error));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clear_stats();
      xfer = 0; issued = 0; max_out = 0; done_cnt = 0; pc_cyc = 0;
      misc_err = 0; span_bad = 0; first_en = -1; first_val = -1;
      salt_base = run_salt + 1;
   endtask

   // accelerator: raise done acc_dly cycles after its start, drop it 2 cycles after start clears
   always @(posedge clk) begin
      pc_prev <= ps_control[0];
      if (ps_control[0] && !pc_prev) run_salt <= run_salt + 1;
      if (acc_force1) begin
         pl0 <= 1'b1; hi_c <= 0; lo_c <= 0;
      end else if (acc_stuck0) begin
         pl0 <= 1'b0; hi_c <= 0; lo_c <= 0;
      end else if (ps_control[0]) begin
         lo_c <= 0; hi_c <= hi_c + 1;
         if (hi_c + 1 >= acc_dly) pl0 <= 1'b1;
      end else begin
         hi_c <= 0;
         if (pl0) begin
            lo_c <= lo_c + 1;
            if (lo_c + 1 >= 2) pl0 <= 1'b0;
         end else lo_c <= 0;
      end
   end
   assign pl_status = {31'h2D5A_1234, pl0};

   // result BRAM: word i of a run holds {run salt, i}, one-cycle read latency
   always @(posedge clk) if (bram_oc_en) bram_oc_rddata <= {run_salt[15:0], bram_oc_addr[17:2]};

   initial forever begin
      @(posedge clk);
      #1 out_ready = $urandom_range(0, 99) < pct;
   end

   // stream model: transfer k of a request is word k%NW of run k/NW
   always @(negedge clk) begin
      cyc++;
      if (issued - xfer > max_out) max_out = issued - xfer;
      if (bram_oc_en) begin
         if (first_en < 0) first_en = cyc;
         if (bram_oc_addr > 4 * (NW - 1) || bram_oc_addr[1:0] != 2'd0 || n_val != 1) misc_err++;
         issued++;
      end
      if (out_valid && first_val < 0) first_val = cyc;
      if (ps_control[0]) pc_cyc++;
      if (ps_control[T-1:1] != '0 || bram_oc_we != 4'h0 || (out_last && !out_valid)) misc_err++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
         idx = xfer % NW;
         exp_d = {16'(salt_base + xfer / NW), 16'(idx)};
         chk("stream_word", 64'({out_last, out_data}), 64'({idx == NW - 1, exp_d}));
         if (n_val != 1) misc_err++;
         if (idx == 0) t0 = cyc;
         if (idx == NW - 1 && cyc - t0 != NW - 1) span_bad++;
         xfer++;
      end
   end

   task automatic run_req(input vec_t v);
      int n;
      bit mid_sent;
      pct = v.pct; acc_dly = v.dly; acc_force1 = v.force1; mid_sent = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      clear_stats();
      start = 1'b1; runs = v.runs;
      @(posedge clk);
      #1 start = 1'b0; runs = 8'($urandom);
      chk("error_clear_on_start", error, 0);
      chk("busy_after_start", busy, 1);
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(posedge clk);
         #1 n++;
         if (n == 3) acc_force1 = 1'b0;
         if (v.mid && !mid_sent && xfer >= 300) begin
            start = 1'b1; runs = 8'd5;
            @(posedge clk);
            #1 start = 1'b0; mid_sent = 1'b1;
         end
      end
      chk("done_within_bound", n < 20000, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("words", xfer, v.exp_words);
      chk("reads", issued, v.exp_words);
      chk("done_pulses", done_cnt, 1);
      chk("outstanding_le_2", max_out <= 2, 1);
      chk("first_valid_latency", first_val - first_en, 2);
      chk("ps_control_cycles", pc_cyc, v.exp_pc);
      chk("misc_protocol", misc_err, 0);
      if (v.pct == 100) chk("full_rate_runs", span_bad, 0);
      chk("idle_busy", busy, 0);
      chk("idle_valid", out_valid, 0);
      chk("idle_nval", n_val, 0);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t rv;
      int n, re;
      vecs[0] = '{8'd2, 100, 10, 1'b0, 1'b0, 2 * NW, 22};
      vecs[1] = '{8'd1, 50, 10, 1'b0, 1'b0, NW, 11};
      vecs[2] = '{8'd1, 100, 10, 1'b1, 1'b0, NW, 1};
      vecs[3] = '{8'd0, 100, 3, 1'b0, 1'b0, NW, 4};
      vecs[4] = '{8'd3, 70, 1, 1'b0, 1'b0, 3 * NW, 6};
      vecs[5] = '{8'd1, 30, 4, 1'b0, 1'b1, NW, 5};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ps_control", ps_control, 0);
      chk("rst_n_val", n_val, 0);
      chk("rst_addr", bram_oc_addr, 0);
      chk("rst_en", bram_oc_en, 0);
      chk("rst_valid", {out_valid, out_last}, 0);
      chk("rst_error", error, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) run_req(vecs[i]);
      for (int i = 0; i < 2; i++) begin
         rv.runs = 8'($urandom_range(0, 3));
         rv.pct = $urandom_range(20, 100);
         rv.dly = $urandom_range(1, 12);
         rv.force1 = 1'b0;
         rv.mid = 1'($urandom_range(0, 1));
         re = rv.runs == 0 ? 1 : int'(rv.runs);
         rv.exp_words = re * NW;
         rv.exp_pc = re * (rv.dly + 1);
         run_req(rv);
      end
      pct = 100; acc_dly = 5;
      repeat (2) @(posedge clk);
      #1;
      clear_stats();
      start = 1'b1; runs = 8'd2;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (xfer < 450 && n < 5000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("reach_word_450", n < 5000, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_ps_control", ps_control, 0);
      chk("async_n_val", n_val, 0);
      chk("async_addr", bram_oc_addr, 0);
      chk("async_en", bram_oc_en, 0);
      chk("async_stream", {out_valid, out_last, out_data}, 0);
      chk("async_done_error", {done, error}, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("abandoned_no_done", done_cnt, 0);
      run_req(vecs[3]);
      pct = 100;
      repeat (2) @(posedge clk);
      #1;
      clear_stats();
      acc_stuck0 = 1'b1;
      start = 1'b1; runs = 8'd1;
      @(posedge clk);
      #1 start = 1'b0;
`ifdef PS_RESULT_READER_TIMEOUT_EN
      n = 0;
      while (busy && n < 500) begin
         @(posedge clk);
         #1 n++;
      end
      chk("timeout_start_cycles", n, 100);
      chk("timeout_error", error, 1);
      chk("timeout_ps_control", ps_control, 0);
      chk("timeout_no_done", done_cnt, 0);
      acc_stuck0 = 1'b0;
      run_req(vecs[1]);
`else
      repeat (300) @(posedge clk);
      #1;
      chk("stuck_busy", busy, 1);
      chk("stuck_ps_control", ps_control, 1);
      chk("stuck_error", error, 0);
      acc_stuck0 = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 5000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("stuck_then_done", done_cnt, 1);
      chk("stuck_then_words", xfer, NW);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "global timeout");
   end
endmodule
